bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Parametrised, iterative binary-to-BCD converter using sequential double-dabble.
- Processes one bit per clock, so area does not grow as a W-deep array of add-3 cells.
- Sits in the Convertors group, between binary datapath results and decimal display/report logic.
- Adds a start/done handshake, optional two's-complement input with sign output, and a decimal-overflow flag.

Parameters:
- W, 16, binary input width (>=2).
- D, 5, number of BCD output digits (>=1).
- SIGNED, 0, 1 = bin is two's complement (magnitude converted, sign reported); 0 = unsigned.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion of bin; sampled only when idle.
- bin  input  W  binary value; captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse: new result valid on bcd/neg/ovf.
- bcd  output  4*D  result digits; digit k = bcd[4k+3:4k], digit 0 = units.
- neg  output  1  result was negative (always 0 when SIGNED=0).
- ovf  output  1  |value| >= 10^D; bcd then holds |value| mod 10^D.

Behaviour:
- Clocking and reset: one clock (clk); reset asynchronous and active-low (rst_n).
- Reset (rst_n=0, any time incl. mid-conversion):
  - state=IDLE; busy, done, bcd, neg, ovf all 0.
  - Internal shift registers and counter cleared.
  - The aborted conversion produces no done pulse.
- FSM states: IDLE, SHIFT.
- IDLE, start=1 at a clock edge:
  - mag <= bin, or its two's-complement negation if SIGNED=1 and bin[W-1]=1; computed in W bits unsigned, so -2^(W-1) gives magnitude 2^(W-1).
  - neg_r <= SIGNED & bin[W-1].
  - acc <= 0; ovf_r <= 0; cnt <= W; state <= SHIFT.
- busy:
  - Registered.
  - 1 from the accepting edge through the edge of the last shift.
- SHIFT, every edge:
  - Each 4-bit digit of acc that is >=5 gets +3 (digits independent; no carry between digits).
  - Then {acc, mag} shifts left one bit; MSB of mag enters acc bit 0.
  - The bit leaving acc bit 4D-1 is ORed into ovf_r.
  - cnt decrements.
- Last shift (cnt==1), on that same edge:
  - The output register loads: bcd <= shifted acc; neg <= neg_r; ovf <= ovf_r OR outgoing bit.
  - done <= 1; busy <= 0; state <= IDLE.
- Latency and throughput:
  - Accepting edge = edge 0; done high in the cycle after edge W; bcd valid in that same cycle.
  - Next start can be accepted at edge W+1, i.e. during the done cycle. Throughput is 1 result per W+1 cycles.
- done is high for exactly one cycle; it is deasserted on the next edge unconditionally.
- Held outputs: bcd/neg/ovf hold the last result until the next completion; they are not cleared at start.
- start while busy: ignored, not queued; bin changes during SHIFT have no effect.
- Negative zero is impossible: bin=0 gives neg=0.
- Overflow: lower D digits are exactly |value| mod 10^D; ovf=1 iff any 1 bit left the top digit.
- No digit of bcd ever exceeds 9.
- Default D=5 covers W=16 unsigned (max 65535). Integrator chooses D >= ceil(W*log10(2)) to make ovf unreachable.

Test Plan:
- W=16, D=5, unsigned, bin=16'hFFFF, start 1 cycle -> busy 16 cycles, done pulse one cycle after edge 16, bcd=20'h65535, ovf=0, neg=0; bin=0 next -> bcd=0.
- W=8, D=3, SIGNED=1, bin=8'h80 -> neg=1, bcd=12'h128. Then bin=8'h7F -> neg=0, bcd=12'h127. Then bin=8'hFF -> neg=1, bcd=12'h001.
- W=16, D=4, bin=12345 -> ovf=1, bcd=16'h2345. Then bin=9999 -> ovf=0, bcd=16'h9999.
- Start at edge 0 with bin=100; pulse start again with bin=7 at edge 5; toggle bin during SHIFT -> single done, bcd=0x00100, busy never drops early.
- Reset asserted asynchronously mid-conversion (edge 8 of 16) -> outputs 0 immediately, no done. After release, new start converts correctly.
- Back-to-back: start held high continuously -> done every W+1 cycles. Random bin against a reference model for 1000 values, checking bcd, ovf, neg, and all digits <=9.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
module bin2bcd_seq #(
  parameter int W      = 16,
  parameter int D      = 5,
  parameter int SIGNED = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd,
  output logic           neg,
  output logic           ovf
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state;
  logic [4*D-1:0] acc;
  logic [W-1:0]   mag;
  logic [CW-1:0]  cnt;
  logic           neg_r;
  logic           ovf_r;

  logic [4*D-1:0] adj;
  logic [4*D-1:0] acc_next;
  logic           out_bit;

  // Add-3 correction is per digit with no carry: a digit >=5 becomes 8..12, which the shift turns into a tens carry.
  always_comb begin
    adj = acc;
    for (int k = 0; k < D; k++) begin
      if (acc[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
    end
    acc_next = {adj[4*D-2:0], mag[W-1]};
    out_bit  = adj[4*D-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      mag   <= '0;
      cnt   <= '0;
      neg_r <= 1'b0;
      ovf_r <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Negation in W bits leaves -2^(W-1) as the unsigned magnitude 2^(W-1).
            if (SIGNED != 0 && bin[W-1])
              mag <= ~bin + 1'b1;
            else
              mag <= bin;
            neg_r <= (SIGNED != 0) && bin[W-1];
            acc   <= '0;
            ovf_r <= 1'b0;
            cnt   <= CW'(W);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc   <= acc_next;
          mag   <= {mag[W-2:0], 1'b0};
          ovf_r <= ovf_r | out_bit;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            bcd   <= acc_next;
            neg   <= neg_r;
            ovf   <= ovf_r | out_bit;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq in three parameter sets
module tb_bin2bcd_seq;

  typedef struct packed {
    logic [19:0] bcd;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [15:0] bin0 = '0, bin2 = '0;
  logic [7:0]  bin1 = '0;
  logic        busy0, done0, neg0, ovf0;
  logic        busy1, done1, neg1, ovf1;
  logic        busy2, done2, neg2, ovf2;
  logic [19:0] bcd0;
  logic [11:0] bcd1;
  logic [15:0] bcd2;

  bin2bcd_seq #(.W(16), .D(5), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .bin(bin0),
    .busy(busy0), .done(done0), .bcd(bcd0), .neg(neg0), .ovf(ovf0));

  bin2bcd_seq #(.W(8), .D(3), .SIGNED(1)) u_dut_s8 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bin(bin1),
    .busy(busy1), .done(done1), .bcd(bcd1), .neg(neg1), .ovf(ovf1));

  bin2bcd_seq #(.W(16), .D(4), .SIGNED(0)) u_dut_d4 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .neg(neg2), .ovf(ovf2));

  int     n_vec = 0;
  int     n_err = 0;
  longint cyc = 0;
  bit     b2b = 1'b0;
  longint last0 = -1, last1 = -1, last2 = -1;
  logic   pd0 = 1'b0;
  exp_t   q0[$], q1[$], q2[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input longint unsigned val, input int wb, input bit sgn, input int d);
    exp_t r;
    longint unsigned v, mag, p, rem;
    v = val & ((64'd1 << wb) - 1);
    mag = v;
    r.neg = 1'b0;
    if (sgn && v[wb-1]) begin
      mag = (64'd1 << wb) - v;
      r.neg = 1'b1;
    end
    p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    r.ovf = (mag >= p);
    rem = mag % p;
    r.bcd = '0;
    for (int k = 0; k < d; k++) begin
      r.bcd[4*k +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return r;
  endfunction

  function automatic logic digits_ok(input logic [19:0] b, input int d);
    for (int k = 0; k < d; k++)
      if (b[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic dn(input int w);
    return (w == 0) ? done0 : (w == 1) ? done1 : done2;
  endfunction

  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst_n && done0) begin
      if (q0.size() == 0) chk("d0_spurious_done", 1, 0);
      else begin
        e = q0.pop_front();
        chk("d0_bcd", 32'(bcd0), 32'(e.bcd));
        chk("d0_neg", 32'(neg0), 32'(e.neg));
        chk("d0_ovf", 32'(ovf0), 32'(e.ovf));
        chk("d0_digits", 32'(digits_ok(bcd0, 5)), 1);
      end
      chk("d0_done_single", 32'(pd0), 0);
      if (b2b) begin
        if (last0 >= 0) chk("d0_interval", 32'(cyc - last0), 17);
        last0 <= cyc;
      end
    end
    pd0 <= done0;
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && done1) begin
      if (q1.size() == 0) chk("d1_spurious_done", 1, 0);
      else begin
        e = q1.pop_front();
        chk("d1_bcd", 32'(bcd1), 32'(e.bcd));
        chk("d1_neg", 32'(neg1), 32'(e.neg));
        chk("d1_ovf", 32'(ovf1), 32'(e.ovf));
        chk("d1_digits", 32'(digits_ok(20'(bcd1), 3)), 1);
      end
      if (b2b) begin
        if (last1 >= 0) chk("d1_interval", 32'(cyc - last1), 9);
        last1 <= cyc;
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst_n && done2) begin
      if (q2.size() == 0) chk("d2_spurious_done", 1, 0);
      else begin
        e = q2.pop_front();
        chk("d2_bcd", 32'(bcd2), 32'(e.bcd));
        chk("d2_neg", 32'(neg2), 32'(e.neg));
        chk("d2_ovf", 32'(ovf2), 32'(e.ovf));
        chk("d2_digits", 32'(digits_ok(20'(bcd2), 4)), 1);
      end
      if (b2b) begin
        if (last2 >= 0) chk("d2_interval", 32'(cyc - last2), 17);
        last2 <= cyc;
      end
    end
  end

  task automatic run(input int which, input logic [15:0] v);
    int t;
    @(negedge clk);
    case (which)
      0: begin bin0 = v; start0 = 1'b1; q0.push_back(model(64'(v), 16, 1'b0, 5)); end
      1: begin bin1 = v[7:0]; start1 = 1'b1; q1.push_back(model(64'(v), 8, 1'b1, 3)); end
      default: begin bin2 = v; start2 = 1'b1; q2.push_back(model(64'(v), 16, 1'b0, 4)); end
    endcase
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    t = 0;
    while (!dn(which) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!dn(which)) chk("run_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int t;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_bcd", 32'(bcd0), 0);
    chk("rst_neg", 32'(neg0), 0);
    chk("rst_ovf", 32'(ovf0), 0);
    rst_n = 1'b1;

    // latency of a full-width conversion
    @(negedge clk);
    bin0 = 16'hFFFF; start0 = 1'b1;
    q0.push_back(model(64'hFFFF, 16, 1'b0, 5));
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (busy0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("lat_busy_cycles", 32'(n), 16);
    chk("lat_done", 32'(done0), 1);
    @(negedge clk);
    chk("lat_done_drop", 32'(done0), 0);

    // start and bin activity while busy are ignored
    @(negedge clk);
    bin0 = 16'd100; start0 = 1'b1;
    q0.push_back(model(64'd100, 16, 1'b0, 5));
    @(negedge clk);
    start0 = 1'b0;
    chk("held_bcd", 32'(bcd0), 32'h65535);
    n = 0;
    while (busy0 && n < 100) begin
      n++;
      if (n == 5) begin start0 = 1'b1; bin0 = 16'd7; end
      else begin start0 = 1'b0; bin0 = 16'($urandom); end
      @(negedge clk);
    end
    start0 = 1'b0;
    chk("busy_ignore_cycles", 32'(n), 16);
    repeat (20) @(negedge clk);

    // asynchronous reset mid-conversion
    bin0 = 16'd999; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy0), 0);
    chk("arst_bcd", 32'(bcd0), 0);
    chk("arst_done", 32'(done0), 0);
    chk("arst_neg", 32'(neg0), 0);
    chk("arst_ovf", 32'(ovf0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    run(0, 16'd12345);
    run(0, 16'd0);

    // signed W=8 D=3
    run(1, 16'h0080);
    run(1, 16'h007F);
    run(1, 16'h00FF);
    run(1, 16'h0000);

    // D=4 overflow
    run(2, 16'd12345);
    run(2, 16'd9999);
    run(2, 16'd65535);

    // back-to-back random with start held high
    b2b = 1'b1;
    fork
      begin
        int a;
        logic [15:0] v;
        logic [15:0] cor[4];
        cor[0] = 16'hFFFF; cor[1] = 16'h0000; cor[2] = 16'h0001; cor[3] = 16'd9999;
        a = 0;
        @(negedge clk);
        start0 = 1'b1;
        while (a < 1000) begin
          if (!busy0) begin
            v = (a < 4) ? cor[a] : 16'($urandom);
            bin0 = v;
            q0.push_back(model(64'(v), 16, 1'b0, 5));
            a++;
          end else bin0 = 16'($urandom);
          @(negedge clk);
        end
        start0 = 1'b0;
      end
      begin
        int a;
        logic [7:0] v;
        logic [7:0] cor[4];
        cor[0] = 8'h80; cor[1] = 8'h00; cor[2] = 8'hFF; cor[3] = 8'h7F;
        a = 0;
        @(negedge clk);
        start1 = 1'b1;
        while (a < 1000) begin
          if (!busy1) begin
            v = (a < 4) ? cor[a] : 8'($urandom);
            bin1 = v;
            q1.push_back(model(64'(v), 8, 1'b1, 3));
            a++;
          end else bin1 = 8'($urandom);
          @(negedge clk);
        end
        start1 = 1'b0;
      end
      begin
        int a;
        logic [15:0] v;
        logic [15:0] cor[4];
        cor[0] = 16'd9999; cor[1] = 16'd10000; cor[2] = 16'hFFFF; cor[3] = 16'd0;
        a = 0;
        @(negedge clk);
        start2 = 1'b1;
        while (a < 1000) begin
          if (!busy2) begin
            v = (a < 4) ? cor[a] : 16'($urandom);
            bin2 = v;
            q2.push_back(model(64'(v), 16, 1'b0, 4));
            a++;
          end else bin2 = 16'($urandom);
          @(negedge clk);
        end
        start2 = 1'b0;
      end
    join
    t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", 32'(q0.size() + q1.size() + q2.size()), 0);
    b2b = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
